// File: rtl/div_ctrl.sv
// Multi-cycle 32-iteration restoring divider controller for DIV/DIVU with HI/LO write strobe.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor short-circuits through a DIVZERO state.
module div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              signed_div,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              cancel,
    output logic              stall_out,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              whilo_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_END
`ifdef DIV_ZERO_FAST_EN
        , S_DIVZERO
`endif
    } state_t;

    state_t              state, next_state;
    logic                accept, load;
    logic                dvd_neg, dvs_neg, dvs_zero;
    logic [DATA_W-1:0]   dvd_raw, dvs_mag;
    logic [2*DATA_W-1:0] work, step;
    logic [5:0]          cnt;
    logic [DATA_W:0]     trial;
    logic                ge;
    logic [DATA_W-1:0]   rem_next, q_raw, r_raw, fix_q, fix_r;

    // {rem, quot}: the shifted-out quotient MSB joins rem to form the 33-bit trial value
    always_comb begin
        trial    = work[2*DATA_W-1:DATA_W-1];
        ge       = (trial >= {1'b0, dvs_mag});
        rem_next = ge ? (work[2*DATA_W-2:DATA_W-1] - dvs_mag) : work[2*DATA_W-2:DATA_W-1];
        step     = {rem_next, work[DATA_W-2:0], ge};
        q_raw    = step[DATA_W-1:0];
        r_raw    = step[2*DATA_W-1:DATA_W];
        if (dvs_zero) begin
            fix_q = '1;
            fix_r = dvd_raw;
        end else begin
            fix_q = (dvd_neg ^ dvs_neg) ? (~q_raw + 1'b1) : q_raw;
            fix_r = dvd_neg ? (~r_raw + 1'b1) : r_raw;
        end
    end

    always_comb begin
        next_state = state;
        stall_out  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !cancel) begin
                    accept     = 1'b1;
                    stall_out  = 1'b1;
                    next_state = S_ON;
`ifdef DIV_ZERO_FAST_EN
                    if (divisor == '0) next_state = S_DIVZERO;
`endif
                end
            end
`ifdef DIV_ZERO_FAST_EN
            S_DIVZERO: begin
                stall_out  = 1'b1;
                busy       = 1'b1;
                load       = 1'b1;
                next_state = S_END;
            end
`endif
            S_ON: begin
                stall_out = 1'b1;
                busy      = 1'b1;
                if (cnt == 6'd31) begin
                    load       = 1'b1;
                    next_state = S_END;
                end
            end
            S_END: begin
                done = 1'b1;
                if (!start) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        // Flush overrides everything; a result not yet written is dropped
        if (cancel) begin
            next_state = S_IDLE;
            load       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            dvd_neg   <= 1'b0;
            dvs_neg   <= 1'b0;
            dvs_zero  <= 1'b0;
            dvd_raw   <= '0;
            dvs_mag   <= '0;
            work      <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            whilo_out <= 1'b0;
        end else begin
            state     <= next_state;
            whilo_out <= load;
            if (accept) begin
                dvd_neg  <= signed_div & dividend[DATA_W-1];
                dvs_neg  <= signed_div & divisor[DATA_W-1];
                dvs_zero <= (divisor == '0);
                dvd_raw  <= dividend;
                dvs_mag  <= (signed_div && divisor[DATA_W-1]) ? (~divisor + 1'b1) : divisor;
                work     <= {{DATA_W{1'b0}},
                             (signed_div && dividend[DATA_W-1]) ? (~dividend + 1'b1) : dividend};
                cnt      <= '0;
            end else if (state == S_ON) begin
                work <= step;
                cnt  <= cnt + 1'b1;
            end
            if (load) begin
                quotient  <= fix_q;
                remainder <= fix_r;
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: expected results queued at issue, compared at done.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rstn, start, signed_div, cancel;
    logic [31:0] dividend, divisor;
    logic        stall_out, busy, done, whilo_out;
    logic [31:0] quotient, remainder;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } res_t;

    res_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_q   = '0;
    logic [31:0] last_r   = '0;

    always #5 clk = ~clk;

    div_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .rstn(rstn), .start(start), .signed_div(signed_div),
        .dividend(dividend), .divisor(divisor), .cancel(cancel),
        .stall_out(stall_out), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .whilo_out(whilo_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic res_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        res_t m;
        logic signed [31:0] sa, sd;
        sa = a;
        sd = b;
        if (b == 32'd0) begin
            m.q = 32'hFFFF_FFFF;
            m.r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m.q = 32'h8000_0000;
            m.r = 32'd0;
        end else if (sgn) begin
            m.q = sa / sd;
            m.r = sa % sd;
        end else begin
            m.q = a / b;
            m.r = a % b;
        end
        return m;
    endfunction

    // Called just after a falling edge; returns just after the falling edge where IDLE is back
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
        res_t e;
        int   stalls;
        int   exp_lat;
        bit   seen;
        stalls  = 0;
        seen    = 0;
        exp_lat = 33;
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) exp_lat = 2;
`endif
        sb.push_back(model(sgn, a, b));
        signed_div = sgn;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            #1;
            if (done) seen = 1;
            else begin
                if (stall_out) stalls++;
                @(negedge clk);
                if (i == 0) begin
                    dividend   = $urandom;
                    divisor    = $urandom;
                    signed_div = ~sgn;
                end
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_stall_cycles"}, stalls, exp_lat);
        chk({tag, "_whilo_first"}, 32'(whilo_out), 32'd1);
        e = sb.pop_front();
        chk({tag, "_quotient"}, quotient, e.q);
        chk({tag, "_remainder"}, remainder, e.r);
        last_q = e.q;
        last_r = e.r;
        @(negedge clk);
        #1;
        chk({tag, "_whilo_once"}, 32'(whilo_out), 32'd0);
        chk({tag, "_done_held"}, 32'(done), 32'd1);
        chk({tag, "_q_held"}, quotient, e.q);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_idle_stall"}, 32'(stall_out), 32'd0);
    endtask

    initial begin
        rstn       = 1'b0;
        start      = 1'b0;
        cancel     = 1'b0;
        signed_div = 1'b0;
        dividend   = '0;
        divisor    = '0;
        #1;
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_whilo", 32'(whilo_out), 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        run_op(1'b0, 32'd100, 32'd7, "divu_100_7");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, "divu_big_2");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd0, "div_neg_by0");
        run_op(1'b0, 32'd5, 32'd0, "divu_5_0");

        // Cancel mid-run: no strobe, previous result kept, next request runs normally
        signed_div = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        start      = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        cancel = 1'b1;
        #1;
        chk("cancel_t10_stall", 32'(stall_out), 32'd1);
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        #1;
        chk("cancel_t11_stall", 32'(stall_out), 32'd0);
        chk("cancel_t11_busy", 32'(busy), 32'd0);
        chk("cancel_t11_whilo", 32'(whilo_out), 32'd0);
        chk("cancel_q_kept", quotient, last_q);
        chk("cancel_r_kept", remainder, last_r);
        @(negedge clk);
        run_op(1'b0, 32'd100, 32'd7, "after_cancel");

        // start together with cancel in IDLE is not accepted
        start  = 1'b1;
        cancel = 1'b1;
        #1;
        chk("idle_cancel_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        #1;
        chk("idle_cancel_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Reset in the middle of an operation, start held through release
        signed_div = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        start      = 1'b1;
        for (int i = 0; i < 15; i++) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_whilo", 32'(whilo_out), 32'd0);
        chk("midrst_q", quotient, 32'd0);
        chk("midrst_r", remainder, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_op(1'b0, 32'd1000, 32'd3, "after_rst");

        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if (i % 4 == 1) b = -b;
            run_op(1'(i % 2), a, b, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
